// File: rtl/mux_nto1_pipe_if.sv
// ---------------------------------------------------------------------------
// mux_nto1_pipe_if
//   Bundles the source channels, the channel select and the output handshake
//   of mux_nto1_pipe into one interface.
//
//   Signals
//     in_data   NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
//     in_valid  NUM_IN        channel i offers a beat
//     in_ready  NUM_IN        channel i beat accepted when in_valid[i]&in_ready[i]
//     sel       SEL_W         channel select (ignored in round-robin builds)
//     out_data  WIDTH         registered output beat
//     out_valid 1             out_data valid
//     out_ready 1             consumer accepts when out_valid&out_ready
//
//   Modports
//     master : producer/consumer side (drives inputs, observes outputs)
//     slave  : selector side (mux_nto1_pipe)
// ---------------------------------------------------------------------------
interface mux_nto1_pipe_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4
);
    localparam int SEL_W = $clog2(NUM_IN);

    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_ready;
    logic [SEL_W-1:0]        sel;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output in_data,
        output in_valid,
        output sel,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  sel,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_valid
    );
endinterface

// File: rtl/mux_nto1_pipe.sv
// ---------------------------------------------------------------------------
// mux_nto1_pipe
//   N:1 datapath selector feeding a 2-entry skid buffer with a valid/ready
//   output handshake. A stalled consumer never causes a beat to be dropped,
//   duplicated or reordered; out_data is always the buffer head register.
//
//   Ports
//     clk    in   rising-edge clock
//     rst_n  in   asynchronous active-low reset
//     bus    slave modport of mux_nto1_pipe_if (in_data, in_valid, in_ready,
//            sel, out_data, out_valid, out_ready)
//
//   Build option
//     MUX_NTO1_RR_ARB_EN : when defined, sel is ignored and a round-robin
//     pointer picks the first valid channel starting at ptr. When undefined
//     the channel is sel (out-of-range sel falls back to channel 0) and no
//     pointer register exists.
// ---------------------------------------------------------------------------
module mux_nto1_pipe #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    mux_nto1_pipe_if.slave   bus
);
    localparam int SEL_W = $clog2(NUM_IN);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    occ_t             occ_p1, occ_d;
    logic [WIDTH-1:0] head_p1, head_d;
    logic [WIDTH-1:0] tail_p1, tail_d;
    logic             vld_p1;

    logic [SEL_W-1:0] grant;
    logic             grant_ok;
    logic             room;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] din_p0;

    // ---- stage p0: channel choice and input handshake (combinational) ----
`ifdef MUX_NTO1_RR_ARB_EN
    logic [SEL_W-1:0] ptr_p1;

    // Scan from the far end back to ptr so the closest valid channel
    // (lowest offset from ptr) is the last assignment and wins.
    always_comb begin
        int idx;
        grant    = '0;
        grant_ok = 1'b0;
        idx      = 0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            idx = int'(ptr_p1) + k;
            if (idx >= NUM_IN) begin
                idx = idx - NUM_IN;
            end
            if (bus.in_valid[idx]) begin
                grant    = SEL_W'(idx);
                grant_ok = 1'b1;
            end
        end
    end

    // Pointer only moves on an actual accept, so a FULL buffer freezes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_p1 <= '0;
        end else if (push) begin
            if (int'(grant) == NUM_IN - 1) begin
                ptr_p1 <= '0;
            end else begin
                ptr_p1 <= grant + SEL_W'(1);
            end
        end
    end
`else
    // Explicit select: channel 0 is the fallback for out-of-range values.
    always_comb begin
        grant    = bus.sel;
        grant_ok = 1'b1;
        if (int'(bus.sel) >= NUM_IN) begin
            grant = '0;
        end
    end
`endif

    // in_ready depends only on registered occupancy and the grant, never on
    // out_ready. rst_n gates it so nothing is offered while reset is held.
    assign room   = (occ_p1 != FULL) && rst_n;
    assign din_p0 = bus.in_data[int'(grant)*WIDTH +: WIDTH];
    assign push   = room && grant_ok && bus.in_valid[grant];
    assign pop    = vld_p1 && bus.out_ready;

    always_comb begin
        bus.in_ready = '0;
        if (room && grant_ok) begin
            bus.in_ready[grant] = 1'b1;
        end
    end

    // Occupancy FSM: decides where an accepted beat lands and how the
    // head advances.
    always_comb begin
        occ_d  = occ_p1;
        head_d = head_p1;
        tail_d = tail_p1;
        case (occ_p1)
            EMPTY: begin
                if (push) begin
                    head_d = din_p0;
                    occ_d  = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    // Head leaves this edge, the new beat replaces it.
                    head_d = din_p0;
                end else if (push) begin
                    tail_d = din_p0;
                    occ_d  = FULL;
                end else if (pop) begin
                    occ_d  = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    head_d = tail_p1;
                    occ_d  = ONE;
                end
            end
            default: begin
                occ_d = EMPTY;
            end
        endcase
    end

    // ---- stage p1: skid buffer registers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_p1  <= EMPTY;
            vld_p1  <= 1'b0;
            head_p1 <= '0;
            tail_p1 <= '0;
        end else begin
            occ_p1  <= occ_d;
            vld_p1  <= (occ_d != EMPTY);
            head_p1 <= head_d;
            tail_p1 <= tail_d;
        end
    end

    assign bus.out_data  = head_p1;
    assign bus.out_valid = vld_p1;

endmodule
